crc_check: RTL and testbench
============================

CRC_CHECK -- requirements
Module: crc_check

Interface
REQ-001 The module SHALL have parameter width, default 32, giving the message length in bits.
REQ-002 The module SHALL have parameter poly_width, default 9, giving the generator polynomial length in bits (degree poly_width-1).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 poly  input  poly_width  generator polynomial, MSB first; sampled only on an accepted start.
REQ-006 start  input  1  begin a new frame check; honoured only in IDLE.
REQ-007 bit_in  input  1  serial frame bit, MSB first: message[width-1] first, last CRC bit last.
REQ-008 bit_valid  input  1  bit_in is valid this cycle; honoured only in SHIFT.
REQ-009 busy  output  1  high while in SHIFT.
REQ-010 done  output  1  one-cycle pulse when a frame check completes.
REQ-011 crc_ok  output  1  high when the last completed frame left a zero remainder.
REQ-012 remainder  output  poly_width-1  remainder of the last completed frame.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
- IDLE->SHIFT on start=1: clear the working remainder to 0, clear the bit counter to 0, latch poly.
- SHIFT->DONE on the edge that accepts bit number width+poly_width-1, the last frame bit.
- DONE->IDLE unconditionally after one cycle.
REQ-014 In SHIFT, each bit_valid=1 edge SHALL update rem as follows, then increment the counter.
- fb = rem[poly_width-2].
- rem = {rem[poly_width-3:0], bit_in} XOR (fb ? latched_poly[poly_width-2:0] : 0).
REQ-015 In SHIFT, bit_valid=0 SHALL stall: rem and the counter hold, with no limit on gap length.
REQ-016 The bit counter SHALL be 8 bits wide, and width+poly_width-1 SHALL NOT exceed 255.
REQ-017 done SHALL be high only during the DONE cycle, i.e. for exactly one clock after the edge that accepts the final bit.
REQ-018 On entering DONE, remainder SHALL load rem and crc_ok SHALL load (rem==0).
REQ-019 remainder and crc_ok SHALL hold until the next frame completes; a start alone does not clear them.
REQ-020 start in SHIFT or DONE SHALL be ignored, and bit_valid in IDLE or DONE SHALL be ignored.
REQ-021 If start and bit_valid are both high in IDLE, only start SHALL take effect; that bit is not counted.
REQ-022 busy SHALL be combinationally equal to (state==SHIFT).

Reset
REQ-023 reset=1 SHALL immediately force the following, independent of clk:
- state IDLE;
- rem, counter, remainder and latched poly to 0;
- done, crc_ok and busy to 0.
REQ-024 A reset mid-frame SHALL abandon the frame with no done pulse, and the next start SHALL begin a clean check.

Configuration
REQ-025 Macro CRC_CHECK_ERR_COUNT_EN defined: add output err_count[15:0], reset to 0.
- err_count increments on each DONE with (rem!=0).
- err_count saturates at 16'hFFFF.
REQ-026 CRC_CHECK_ERR_COUNT_EN undefined: err_count port and logic absent; all other behaviour identical.

Verification
REQ-027 The bench SHALL cover the following directed scenarios (poly=9'h107 unless stated).
- Frame 32'h00000000 + 8'h00 -> done one pulse, crc_ok=1, remainder=8'h00.
- Frame 32'h00000001 + 8'h07 -> crc_ok=1, remainder=8'h00.
- Frame 32'h00000001 + 8'h06 -> crc_ok=0, remainder=8'h01.
- Frame 32'h00000001 + 8'h07 with random bit_valid gaps up to 5 cycles -> same as the no-gap result, done exactly 40 valid bits after start.
- reset after 10 accepted bits -> busy=0 and remainder=0 at once, no done; next frame 32'h00000001 + 8'h07 gives crc_ok=1.
- With CRC_CHECK_ERR_COUNT_EN: three bad frames then one good frame -> err_count=3; preloaded at 16'hFFFF plus a bad frame -> stays 16'hFFFF.

Source files
------------

// File: rtl/crc_check.sv
// Serial CRC frame checker: shifts message+CRC bits MSB first, flags zero remainder.
// Optional CRC_CHECK_ERR_COUNT_EN adds a saturating bad-frame counter (err_count).
module crc_check #(
    parameter int width      = 32,
    parameter int poly_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [poly_width-1:0] poly,
    input  logic                  start,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  crc_ok,
`ifdef CRC_CHECK_ERR_COUNT_EN
    output logic [15:0]           err_count,
`endif
    output logic [poly_width-2:0] remainder
);

    localparam int RW = poly_width - 1;
    localparam logic [7:0] LAST = 8'(width + poly_width - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [RW-1:0] rem_q;
    logic [RW-1:0] rem_d;
    logic [RW-1:0] poly_q;
    logic [7:0]    cnt_q;
    logic          done_q;
    logic          ok_q;
    logic [RW-1:0] remainder_q;

    // The generator's leading term is implicit in the feedback tap.
    logic unused_poly_msb;
    assign unused_poly_msb = poly[poly_width-1];

    always_comb begin
        rem_d = {rem_q[RW-2:0], bit_in};
        if (rem_q[RW-1]) begin
            rem_d = rem_d ^ poly_q;
        end
    end

`ifdef CRC_CHECK_ERR_COUNT_EN
    logic [15:0] err_q;
    assign err_count = err_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            poly_q      <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            remainder_q <= '0;
`ifdef CRC_CHECK_ERR_COUNT_EN
            err_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        poly_q  <= poly[RW-1:0];
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LAST) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            remainder_q <= rem_d;
                            ok_q        <= (rem_d == '0);
`ifdef CRC_CHECK_ERR_COUNT_EN
                            if (rem_d != '0 && err_q != 16'hFFFF) begin
                                err_q <= err_q + 16'd1;
                            end
`endif
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign crc_ok    = ok_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_crc_check.sv
// Randomized self-checking bench for crc_check against a long-division model.
// Build with CRC_CHECK_ERR_COUNT_EN to also exercise err_count.
module tb_crc_check;
    localparam int W  = 32;
    localparam int PW = 9;
    localparam int N  = W + PW - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW-1:0] poly;
    logic          start;
    logic          bit_in;
    logic          bit_valid;
    logic          busy;
    logic          done;
    logic          crc_ok;
    logic [PW-2:0] remainder;
`ifdef CRC_CHECK_ERR_COUNT_EN
    logic [15:0]   err_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] last_rem;

    always #5 clk = ~clk;

    crc_check #(.width(W), .poly_width(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .poly      (poly),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
`ifdef CRC_CHECK_ERR_COUNT_EN
        .err_count (err_count),
`endif
        .remainder (remainder)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Polynomial long division over GF(2): frame mod poly.
    function automatic logic [7:0] ref_rem(input logic [39:0] fr,
                                           input logic [8:0] p);
        logic [39:0] r;
        r = fr;
        for (int i = 39; i >= 8; i--) begin
            if (r[i]) r = r ^ ({31'b0, p} << (i - 8));
        end
        return r[7:0];
    endfunction

    task automatic run_frame(input logic [39:0] fr, input logic [8:0] p,
                             input int gap);
        logic [7:0] er;
        int early;
        er = ref_rem(fr, p);
        early = 0;
        start = 1'b1;
        poly = p;
        bit_valid = 1'($urandom);
        bit_in = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        bit_valid = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("rem_held_on_start", 32'(remainder), 32'(last_rem));
        for (int i = N - 1; i >= 0; i--) begin
            int g;
            g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                bit_valid = 1'b0;
                bit_in = 1'($urandom);
                start = 1'($urandom);
                @(posedge clk); #1;
                if (done) early++;
            end
            bit_valid = 1'b1;
            bit_in = fr[i];
            start = 1'($urandom);
            @(posedge clk); #1;
            if (i > 0 && done) early++;
        end
        start = 1'b0;
        bit_valid = 1'b1;
        bit_in = 1'($urandom);
        check("no_early_done", 32'(early), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd0);
        check("remainder", 32'(remainder), 32'(er));
        check("crc_ok", 32'(crc_ok), 32'(er == 8'd0));
        @(posedge clk); #1;
        bit_valid = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        last_rem = er;
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        last_rem = 8'd0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] msg;
        logic [8:0]  p;
        logic [7:0]  good;
        reset = 1'b1;
        start = 1'b0;
        poly = '0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        last_rem = 8'd0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ok", 32'(crc_ok), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_frame({32'h0, 8'h00}, 9'h107, 0);
        check("zero_ok", 32'(crc_ok), 32'd1);
        run_frame({32'h1, 8'h07}, 9'h107, 0);
        check("good_ok", 32'(crc_ok), 32'd1);
        run_frame({32'h1, 8'h06}, 9'h107, 0);
        check("bad_ok", 32'(crc_ok), 32'd0);
        check("bad_rem", 32'(remainder), 32'h01);
        run_frame({32'h1, 8'h07}, 9'h107, 5);
        check("gap_ok", 32'(crc_ok), 32'd1);
        check("gap_rem", 32'(remainder), 32'h00);

        // Leave a nonzero remainder, then abandon a frame with reset.
        run_frame({32'h1, 8'h06}, 9'h107, 0);
        start = 1'b1;
        poly = 9'h107;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_valid = 1'b1;
            bit_in = 1'($urandom);
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rem", 32'(remainder), 32'd0);
        check("mid_rst_ok", 32'(crc_ok), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        last_rem = 8'd0;
        run_frame({32'h1, 8'h07}, 9'h107, 0);
        check("post_rst_ok", 32'(crc_ok), 32'd1);

        for (int f = 0; f < 24; f++) begin
            msg = $urandom;
            p = {1'b1, 8'($urandom)};
            good = ref_rem({msg, 8'h00}, p);
            if (f % 2 == 0) run_frame({msg, good}, p, f % 4);
            else run_frame({msg, 8'($urandom)}, p, f % 4);
        end

`ifdef CRC_CHECK_ERR_COUNT_EN
        do_reset();
        check("err_rst", 32'(err_count), 32'd0);
        for (int f = 0; f < 3; f++) run_frame({32'h1, 8'h06}, 9'h107, 0);
        run_frame({32'h1, 8'h07}, 9'h107, 0);
        check("err_three", 32'(err_count), 32'd3);
        dut.err_q = 16'hFFFF;
        run_frame({32'h1, 8'h06}, 9'h107, 0);
        check("err_sat", 32'(err_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
